// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubbles and EX operand forwarding.
// Optional bubble counter output enabled by defining EX_BUBBLE_CNT_EN.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd_dst,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic [3:0]    id_aluop,
    input  logic          id_alusrc,
    input  logic          id_shift,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          stall_in,
    input  logic          flush,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic          hazard_stall,
    output logic [DW-1:0] alu_input1,
    output logic [DW-1:0] alu_input2,
    output logic [3:0]    alu_aluop,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic [RW-1:0] ex_rd,
    output logic [DW-1:0] ex_store_data
`ifdef EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]   bubble_cnt
`endif
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [3:0]    aluop;
        logic          alusrc;
        logic          shift;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    logic   load_use;
    logic   bubble;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    always_comb begin
        load_use = q.valid && q.memread && (q.rd != '0) && id_valid &&
                   ((q.rd == id_rs) || (id_uses_rt && (q.rd == id_rt)));
    end

    assign hazard_stall = load_use && !flush;

    always_comb begin
        d      = q;
        bubble = 1'b0;
        if (flush) begin
            d      = '0;
            bubble = 1'b1;
        end else if (stall_in) begin
            d      = q;
        end else if (load_use) begin
            d      = '0;
            bubble = 1'b1;
        end else begin
            d.valid    = id_valid;
            d.rs       = id_rs;
            d.rt       = id_rt;
            d.rd       = id_rd_dst;
            d.rs_data  = id_rs_data;
            d.rt_data  = id_rt_data;
            d.imm      = id_imm;
            d.shamt    = id_shamt;
            d.aluop    = id_aluop;
            d.alusrc   = id_alusrc;
            d.shift    = id_shift;
            d.regwrite = id_regwrite;
            d.memread  = id_memread;
            d.memwrite = id_memwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

`ifdef EX_BUBBLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

    // MEM result is younger than WB, so it wins; r0 is hardwired zero.
    always_comb begin
        fwd_rs = q.rs_data;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == q.rs)) begin
            fwd_rs = mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == q.rs)) begin
            fwd_rs = wb_result;
        end
    end

    always_comb begin
        fwd_rt = q.rt_data;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == q.rt)) begin
            fwd_rt = mem_result;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == q.rt)) begin
            fwd_rt = wb_result;
        end
    end

    assign alu_input1    = q.shift ? {{(DW-5){1'b0}}, q.shamt} : fwd_rs;
    assign alu_input2    = q.alusrc ? q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_aluop     = q.aluop;
    assign ex_valid      = q.valid;
    assign ex_regwrite   = q.regwrite;
    assign ex_memread    = q.memread;
    assign ex_memwrite   = q.memwrite;
    assign ex_rd         = q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hazard,
// stall, flush and reset sequences.
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd_dst;
    logic          id_uses_rt;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_shamt;
    logic [3:0]    id_aluop;
    logic          id_alusrc, id_shift;
    logic          id_regwrite, id_memread, id_memwrite;
    logic          stall_in, flush;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;
    logic          hazard_stall;
    logic [DW-1:0] alu_input1, alu_input2, ex_store_data;
    logic [3:0]    alu_aluop;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [RW-1:0] ex_rd;
`ifdef EX_BUBBLE_CNT_EN
    logic [31:0]   bubble_cnt;
    logic [31:0]   exp_bc;
`endif

    id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd_dst(id_rd_dst), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_shift(id_shift),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite),
        .stall_in(stall_in), .flush(flush),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
        .hazard_stall(hazard_stall),
        .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_aluop(alu_aluop),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data)
`ifdef EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_rs = '0; id_rt = '0; id_rd_dst = '0;
        id_uses_rt = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_shamt = '0; id_aluop = '0; id_alusrc = 0; id_shift = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    endtask

    task automatic no_fwd();
        mem_regwrite = 0; mem_rd = '0; mem_result = '0;
        wb_regwrite = 0; wb_rd = '0; wb_result = '0;
    endtask

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt;
        logic [3:0]  aluop;
        logic        alusrc, shift, regwrite, memwrite;
        logic        mrw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        wrw;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] e1, e2, esd;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 5'd0, 4'd0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7};
        vt[1] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'hFFFFFFFC, 5'd0, 4'd0,
                  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 5'd0, 32'd0, 32'd5, 32'hFFFFFFFC, 32'd7};
        vt[2] = '{5'd3, 5'd4, 5'd10, 32'd1, 32'd9, 32'd0, 5'd0, 4'd1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11,
                  1'b1, 5'd3, 32'h22, 32'h11, 32'd9, 32'd9};
        vt[3] = '{5'd3, 5'd4, 5'd10, 32'd1, 32'd9, 32'd0, 5'd0, 4'd1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h11,
                  1'b1, 5'd3, 32'h22, 32'h22, 32'd9, 32'd9};
        vt[4] = '{5'd0, 5'd4, 5'd10, 32'd1, 32'd9, 32'd0, 5'd0, 4'd1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h11,
                  1'b1, 5'd0, 32'h22, 32'd1, 32'd9, 32'd9};
        vt[5] = '{5'd9, 5'd5, 5'd11, 32'hDEAD, 32'd1, 32'd0, 5'd4, 4'b0010,
                  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,
                  1'b0, 5'd0, 32'd0, 32'd4, 32'd1, 32'd1};
        vt[6] = '{5'd1, 5'd6, 5'd0, 32'd2, 32'h33, 32'h10, 5'd0, 4'd0,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,
                  1'b1, 5'd6, 32'h44, 32'd2, 32'h10, 32'h44};
        vt[7] = '{5'd1, 5'd7, 5'd0, 32'd2, 32'd3, 32'd0, 5'd0, 4'd0,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h55,
                  1'b1, 5'd7, 32'h66, 32'd2, 32'h55, 32'h55};

        rst = 1; stall_in = 0; flush = 0;
        idle_id(); no_fwd();
`ifdef EX_BUBBLE_CNT_EN
        exp_bc = 0;
`endif
        #2;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset aluop", {28'd0, alu_aluop}, 32'd0);
        chk("reset in1", alu_input1, 32'd0);
        chk("reset in2", alu_input2, 32'd0);
        chk("reset hazard", {31'd0, hazard_stall}, 32'd0);
        tick();
        rst = 0;

        for (int i = 0; i < 8; i++) begin
            no_fwd();
            id_valid = 1; id_rs = vt[i].rs; id_rt = vt[i].rt;
            id_rd_dst = vt[i].rd; id_uses_rt = 1;
            id_rs_data = vt[i].rs_data; id_rt_data = vt[i].rt_data;
            id_imm = vt[i].imm; id_shamt = vt[i].shamt;
            id_aluop = vt[i].aluop; id_alusrc = vt[i].alusrc;
            id_shift = vt[i].shift; id_regwrite = vt[i].regwrite;
            id_memread = 0; id_memwrite = vt[i].memwrite;
            tick();
            idle_id();
            mem_regwrite = vt[i].mrw; mem_rd = vt[i].mrd;
            mem_result = vt[i].mres;
            wb_regwrite = vt[i].wrw; wb_rd = vt[i].wrd;
            wb_result = vt[i].wres;
            #1;
            chk($sformatf("v%0d in1", i), alu_input1, vt[i].e1);
            chk($sformatf("v%0d in2", i), alu_input2, vt[i].e2);
            chk($sformatf("v%0d store", i), ex_store_data, vt[i].esd);
            chk($sformatf("v%0d aluop", i), {28'd0, alu_aluop},
                {28'd0, vt[i].aluop});
            chk($sformatf("v%0d valid", i), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("v%0d rd", i), {27'd0, ex_rd}, {27'd0, vt[i].rd});
            chk($sformatf("v%0d regwrite", i), {31'd0, ex_regwrite},
                {31'd0, vt[i].regwrite});
            chk($sformatf("v%0d memwrite", i), {31'd0, ex_memwrite},
                {31'd0, vt[i].memwrite});
        end

        // Load-use: lw r8 in EX, consumer of r8 in ID.
        no_fwd(); idle_id();
        id_valid = 1; id_rs = 5'd1; id_rd_dst = 5'd8;
        id_memread = 1; id_regwrite = 1;
        tick();
        idle_id();
        id_valid = 1; id_rs = 5'd8; id_rt = 5'd2; id_rd_dst = 5'd9;
        id_uses_rt = 1; id_rs_data = 32'h77; id_aluop = 4'd1;
        id_regwrite = 1;
        #1;
        chk("lu hazard", {31'd0, hazard_stall}, 32'd1);
        flush = 1; #1;
        chk("lu hazard masked by flush", {31'd0, hazard_stall}, 32'd0);
        flush = 0;
        tick();
`ifdef EX_BUBBLE_CNT_EN
        exp_bc = exp_bc + 1;
        chk("lu bubble_cnt", bubble_cnt, exp_bc);
`endif
        chk("lu bubble valid", {31'd0, ex_valid}, 32'd0);
        chk("lu bubble regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("lu bubble hazard clear", {31'd0, hazard_stall}, 32'd0);
        tick();
        chk("lu capture valid", {31'd0, ex_valid}, 32'd1);
        chk("lu capture rd", {27'd0, ex_rd}, 32'd9);
        chk("lu capture in1", alu_input1, 32'h77);
        chk("lu capture aluop", {28'd0, alu_aluop}, 32'd1);

        // rt match only counts when rt is read; stall holds the hazard.
        idle_id();
        id_valid = 1; id_rs = 5'd1; id_rd_dst = 5'd8;
        id_memread = 1; id_regwrite = 1;
        tick();
        idle_id();
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd8; id_uses_rt = 0;
        #1;
        chk("lu rt unused", {31'd0, hazard_stall}, 32'd0);
        id_uses_rt = 1; #1;
        chk("lu rt used", {31'd0, hazard_stall}, 32'd1);
        stall_in = 1;
        tick();
        chk("stall+lu hold memread", {31'd0, ex_memread}, 32'd1);
        chk("stall+lu hold rd", {27'd0, ex_rd}, 32'd8);
        chk("stall+lu hazard", {31'd0, hazard_stall}, 32'd1);
`ifdef EX_BUBBLE_CNT_EN
        chk("stall no bubble_cnt", bubble_cnt, exp_bc);
`endif
        stall_in = 0;
        tick();
`ifdef EX_BUBBLE_CNT_EN
        exp_bc = exp_bc + 1;
`endif
        chk("lu2 bubble valid", {31'd0, ex_valid}, 32'd0);

        // flush beats stall_in.
        idle_id();
        id_valid = 1; id_rd_dst = 5'd12; id_regwrite = 1;
        tick();
        flush = 1; stall_in = 1;
        tick();
        flush = 0; stall_in = 0;
`ifdef EX_BUBBLE_CNT_EN
        exp_bc = exp_bc + 1;
        chk("flush bubble_cnt", bubble_cnt, exp_bc);
`endif
        chk("flush+stall valid", {31'd0, ex_valid}, 32'd0);
        chk("flush+stall regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("flush+stall rd", {27'd0, ex_rd}, 32'd0);

        // Three-cycle freeze; forwarding still acts on held operands.
        idle_id();
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_rd_dst = 5'd13;
        id_rs_data = 32'hAB; id_rt_data = 32'hCD; id_aluop = 4'd3;
        id_regwrite = 1; id_memwrite = 1;
        tick();
        stall_in = 1;
        id_rd_dst = 5'd14; id_rs_data = 32'd0; id_aluop = 4'd5;
        id_memwrite = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d valid", c), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("hold%0d rd", c), {27'd0, ex_rd}, 32'd13);
            chk($sformatf("hold%0d aluop", c), {28'd0, alu_aluop}, 32'd3);
            chk($sformatf("hold%0d in1", c), alu_input1, 32'hAB);
            chk($sformatf("hold%0d store", c), ex_store_data, 32'hCD);
            chk($sformatf("hold%0d memwrite", c), {31'd0, ex_memwrite}, 32'd1);
        end
        mem_regwrite = 1; mem_rd = 5'd1; mem_result = 32'h99;
        #1;
        chk("hold fwd in1", alu_input1, 32'h99);
        stall_in = 0; no_fwd();

        // Asynchronous reset mid-stream.
        idle_id();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h5A; id_rt_data = 32'h6B;
        id_aluop = 4'd7; id_rd_dst = 5'd4; id_regwrite = 1;
        tick();
        chk("pre-reset valid", {31'd0, ex_valid}, 32'd1);
        rst = 1;
        #1;
        chk("midreset valid", {31'd0, ex_valid}, 32'd0);
        chk("midreset aluop", {28'd0, alu_aluop}, 32'd0);
        chk("midreset in1", alu_input1, 32'd0);
        chk("midreset in2", alu_input2, 32'd0);
        chk("midreset hazard", {31'd0, hazard_stall}, 32'd0);
`ifdef EX_BUBBLE_CNT_EN
        exp_bc = 0;
        chk("midreset bubble_cnt", bubble_cnt, exp_bc);
`endif
        tick();
        rst = 0;
        tick();
        chk("post-reset capture in1", alu_input1, 32'h5A);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS pipeline.
- Captures decoded instruction fields each cycle and inserts bubbles on load-use hazards and flushes.
- Drives the ALU's input1/input2/aluop through MEM→EX and WB→EX forwarding muxes.
- Passes control and store data downstream to EX/MEM.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RW  source register indices
- id_rd_dst  in  RW  destination index (already selected rd/rt/31)
- id_uses_rt  in  1  instruction reads rt
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  immediate, already extended
- id_shamt  in  5  shift amount
- id_aluop  in  4  ALU opcode (0000 add … 1001 sra)
- id_alusrc  in  1  input2 := immediate
- id_shift  in  1  input1 := shamt
- id_regwrite, id_memread, id_memwrite  in  1  control bits
- stall_in  in  1  global freeze (memory wait)
- flush  in  1  squash the instruction entering EX (branch/jump redirect)
- mem_regwrite  in  1  EX/MEM writes a register
- mem_rd  in  RW  EX/MEM destination
- mem_result  in  DW  EX/MEM ALU result
- wb_regwrite  in  1  MEM/WB writes a register
- wb_rd  in  RW  MEM/WB destination
- wb_result  in  DW  MEM/WB writeback value
- hazard_stall  out  1  hold PC and IF/ID (load-use)
- alu_input1, alu_input2  out  DW  ALU operands
- alu_aluop  out  4  ALU opcode
- ex_valid, ex_regwrite, ex_memread, ex_memwrite  out  1  registered control
- ex_rd  out  RW  registered destination
- ex_store_data  out  DW  forwarded rt value for sw

Behaviour:
- Registered fields: valid, rs, rt, rd, rs_data, rt_data, imm, shamt, aluop, alusrc, shift, regwrite, memread, memwrite.
- Reset (async, rst=1): all registered fields 0. Outputs therefore: ex_valid=0, all controls=0, aluop=0000, alu_input1=alu_input2=ex_store_data=0, hazard_stall=0.
- Load-use detect (combinational): load_use = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- hazard_stall = load_use & !flush.
- Posedge update, priority order:
  1. flush → bubble
  2. stall_in → hold all fields
  3. load_use → bubble
  4. otherwise → capture ID fields (valid=id_valid)
- Bubble: valid, regwrite, memread, memwrite = 0; aluop=0000; every other field 0.
- flush+stall_in same cycle: flush wins. stall_in+load_use: hold; hazard_stall stays asserted.
- Forwarding (combinational, applied to registered rs/rt every cycle, including while held):
  - fwd_rs = mem_result if mem_regwrite & mem_rd!=0 & mem_rd==rs; else wb_result if wb_regwrite & wb_rd!=0 & wb_rd==rs; else rs_data.
  - fwd_rt: same rule on rt.
  - MEM has priority over WB. Register 0 is never forwarded.
- Operand muxes:
  - alu_input1 = shift ? {zeros, shamt} : fwd_rs (ALU takes shift amount from input1).
  - alu_input2 = alusrc ? imm : fwd_rt.
  - ex_store_data = fwd_rt.
  - alu_aluop = registered aluop.
- Latency: ID fields appear at outputs 1 cycle after capture; operand-mux path is zero-cycle.
- Reset mid-operation: immediate clear; the in-flight instruction is lost.

Optional Feature:
- Macro: EX_BUBBLE_CNT_EN.
- Defined:
  - adds output bubble_cnt (32 bits), reset to 0.
  - increments by 1 on every posedge where a bubble is written (flush or load_use path, not hold).
  - wraps 0xFFFFFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-stream → same cycle ex_valid=0, alu_aluop=0000, alu_input1=alu_input2=0, hazard_stall=0.
- Pass-through: id_rs_data=5, id_rt_data=7, aluop=0000, alusrc=0, no forwarding → next cycle alu_input1=5, alu_input2=7, ex_valid=1; with alusrc=1, imm=0xFFFFFFFC → alu_input2=0xFFFFFFFC.
- Forward priority: EX rs=3, rs_data=1, mem_rd=3/mem_result=0x11, wb_rd=3/wb_result=0x22, both regwrite → alu_input1=0x11. Drop mem_regwrite → 0x22. rs=0 with mem_rd=0 → 1.
- Load-use: EX lw with rd=8, ID rs=8 → hazard_stall=1. Next cycle ex_valid=0, ex_regwrite=0. Following cycle captures the held ID instruction. bubble_cnt +1 if EX_BUBBLE_CNT_EN.
- Priority: flush=1 with stall_in=1 → bubble. stall_in=1 alone for 3 cycles → all ex_* outputs unchanged.
- Shift: id_shift=1, shamt=4, aluop=0010, rt_data=0x1 → alu_input1=4, alu_input2=0x1.
